serial_bit_gen: RTL and testbench

SERIAL_BIT_GEN -- requirements
Module: serial_bit_gen

---
 rtl/serial_bit_gen.sv | 116 +++++++++++
 tb/tb_serial_bit_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_gen.sv
// Parallel-to-serial bit generator with a one-entry holding register.
// Streams words back-to-back onto x_out for a single-bit sequence detector.
module serial_bit_gen #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             hold_full_q;
  logic             hold_full_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;
  logic [CW-1:0]    bit_idx;

  logic accept;
  logic last_bit;
  logic xfer;

  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & ~hold_full_q & ~flush;
  assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST);
  // Hold-to-shift moves only when the shifter is free or about to be.
  assign xfer       = hold_full_q &&
                      ((state_q == IDLE) || last_bit);

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = SHIFT;
          shift_d   = hold_q;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (hold_full_q) begin
            shift_d = hold_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    endcase

    // accept and xfer are disjoint: accept needs an empty hold.
    if (xfer) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = data_in;
    end

    if (flush) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign bit_idx   = MSB_FIRST ? (LAST - bit_cnt_q) : bit_cnt_q;
  assign x_valid   = (state_q == SHIFT);
  assign x_out     = x_valid ? shift_q[bit_idx] : IDLE_LEVEL;
  assign word_done = last_bit;

endmodule

// File: tb/tb_serial_bit_gen.sv
// Directed bench for serial_bit_gen: MSB-first default
// instance plus an LSB-first instance.
module tb_serial_bit_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       load_valid;
  logic [7:0] data_in;
  logic       load_ready;
  logic       x_out;
  logic       x_valid;
  logic       word_done;

  logic       flush_l;
  logic       load_valid_l;
  logic [7:0] data_in_l;
  logic       load_ready_l;
  logic       x_out_l;
  logic       x_valid_l;
  logic       word_done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  serial_bit_gen dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .load_valid (load_valid),
    .data_in    (data_in),
    .load_ready (load_ready),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .word_done  (word_done)
  );

  serial_bit_gen #(
    .WIDTH      (8),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) dut_lsb (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush_l),
    .load_valid (load_valid_l),
    .data_in    (data_in_l),
    .load_ready (load_ready_l),
    .x_out      (x_out_l),
    .x_valid    (x_valid_l),
    .word_done  (word_done_l)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_xv"}, {31'd0, x_valid}, 32'd0);
    check({tag, "_xo"}, {31'd0, x_out}, 32'd1);
    check({tag, "_wd"}, {31'd0, word_done}, 32'd0);
  endtask

  initial begin
    logic [7:0]  w;
    logic [23:0] stream;
    logic        exp_lr;
    logic        exp_wd;

    reset        = 1'b1;
    flush        = 1'b0;
    load_valid   = 1'b0;
    data_in      = 8'h00;
    flush_l      = 1'b0;
    load_valid_l = 1'b0;
    data_in_l    = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_idle("rst");
    check("rst_lr", {31'd0, load_ready}, 32'd1);
    check("rst_lsb_lr", {31'd0, load_ready_l}, 32'd1);

    // Single word A5, MSB first, latency 1.
    w          = 8'hA5;
    load_valid = 1'b1;
    data_in    = w;
    tick();
    load_valid = 1'b0;
    data_in    = 8'hFF;
    check("a5_acc_lr", {31'd0, load_ready}, 32'd0);
    check("a5_acc_xv", {31'd0, x_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("a5_bit%0d", i),
            {31'd0, x_out}, {31'd0, w[7-i]});
      check($sformatf("a5_xv%0d", i),
            {31'd0, x_valid}, 32'd1);
      check($sformatf("a5_wd%0d", i),
            {31'd0, word_done}, {31'd0, i == 7});
    end
    tick();
    check_idle("a5_end");
    check("a5_end_lr", {31'd0, load_ready}, 32'd1);

    // F0, 0F back-to-back, then 3C under backpressure.
    stream     = 24'hF00F3C;
    load_valid = 1'b1;
    data_in    = 8'hF0;
    for (int k = 0; k <= 25; k++) begin
      tick();
      if (k == 0)  data_in = 8'h0F;
      if (k == 2)  data_in = 8'h3C;
      if (k == 10) begin
        load_valid = 1'b0;
        data_in    = 8'h00;
      end
      exp_lr = (k == 1) || (k == 9) || (k >= 17);
      exp_wd = (k == 8) || (k == 16) || (k == 24);
      check($sformatf("b2b_lr%0d", k),
            {31'd0, load_ready}, {31'd0, exp_lr});
      if (k >= 1 && k <= 24) begin
        check($sformatf("b2b_xv%0d", k),
              {31'd0, x_valid}, 32'd1);
        check($sformatf("b2b_bit%0d", k),
              {31'd0, x_out}, {31'd0, stream[24-k]});
        check($sformatf("b2b_wd%0d", k),
              {31'd0, word_done}, {31'd0, exp_wd});
      end
      if (k == 25) check_idle("b2b_end");
    end

    // Reset after 3rd bit of A5 while C3 is held.
    load_valid = 1'b1;
    data_in    = 8'hA5;
    tick();
    data_in = 8'hC3;
    tick();
    check("rs_bit0", {31'd0, x_out}, 32'd1);
    tick();
    check("rs_held_lr", {31'd0, load_ready}, 32'd0);
    check("rs_bit1", {31'd0, x_out}, 32'd0);
    tick();
    check("rs_bit2", {31'd0, x_out}, 32'd1);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    check_idle("rs_after");
    check("rs_after_lr", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rs_quiet_xv%0d", i),
            {31'd0, x_valid}, 32'd0);
    end

    // Flush in SHIFT with a held word and a competing load.
    load_valid = 1'b1;
    data_in    = 8'hA5;
    tick();
    data_in = 8'h5A;
    tick();
    tick();
    check("fl_held_lr", {31'd0, load_ready}, 32'd0);
    flush   = 1'b1;
    data_in = 8'hFF;
    tick();
    flush      = 1'b0;
    load_valid = 1'b0;
    check_idle("fl_after");
    check("fl_after_lr", {31'd0, load_ready}, 32'd1);
    tick();
    check_idle("fl_quiet");
    check("fl_quiet_lr", {31'd0, load_ready}, 32'd1);

    w          = 8'h80;
    load_valid = 1'b1;
    data_in    = w;
    tick();
    load_valid = 1'b0;
    check("w80_lat_xv", {31'd0, x_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("w80_bit%0d", i),
            {31'd0, x_out}, {31'd0, w[7-i]});
      check($sformatf("w80_xv%0d", i),
            {31'd0, x_valid}, 32'd1);
    end
    tick();
    check_idle("w80_end");

    // LSB-first instance, word 01.
    load_valid_l = 1'b1;
    data_in_l    = 8'h01;
    tick();
    load_valid_l = 1'b0;
    data_in_l    = 8'h00;
    check("lsb_lat_xv", {31'd0, x_valid_l}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("lsb_bit%0d", i),
            {31'd0, x_out_l}, {31'd0, i == 0});
      check($sformatf("lsb_xv%0d", i),
            {31'd0, x_valid_l}, 32'd1);
      check($sformatf("lsb_wd%0d", i),
            {31'd0, word_done_l}, {31'd0, i == 7});
    end
    tick();
    check("lsb_end_xv", {31'd0, x_valid_l}, 32'd0);
    check("lsb_end_xo", {31'd0, x_out_l}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
